// File: rtl/mantissa_divider24.sv
// Radix-2 restoring mantissa divider: quo = floor(A*2^(QW-1)/B), sticky = remainder != 0, dz = B == 0.
// Latency: out_valid rises QW edges after the accepting edge (1 edge for B == 0); one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready stays low from accept until the result is taken.
module mantissa_divider24 #(
  parameter int MW = 24,
  parameter int QW = MW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] A,
  input  logic [MW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quo,
  output logic          sticky,
  output logic          dz
);

  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [MW:0]   rem;
  logic [MW-1:0] div;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;

  logic [MW+1:0] diff;
  logic [MW:0]   rem_next;
  logic [QW-1:0] q_next;

  // One restoring step: trial subtract, keep the difference when it does not go negative.
  // rem < 2*div always holds, so the doubled remainder fits in MW+1 bits.
  always_comb begin
    diff     = {1'b0, rem} - {2'b00, div};
    rem_next = rem << 1;
    q_next   = {q[QW-2:0], 1'b0};
    if (!diff[MW+1]) begin
      rem_next = diff[MW:0] << 1;
      q_next   = {q[QW-2:0], 1'b1};
    end
  end

  // Control FSM and datapath registers; all handshake and result outputs are registered.
  // A zero divisor parks in DONE for one cycle before out_valid rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quo       <= '0;
      sticky    <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      div       <= '0;
      q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem      <= {1'b0, A};
            div      <= B;
            q        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (B == '0) begin
              state  <= DONE;
              quo    <= '1;
              sticky <= 1'b1;
              dz     <= 1'b1;
            end else begin
              state  <= RUN;
              dz     <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(QW - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quo       <= q_next;
            sticky    <= |rem_next;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_divider24.sv
// Self-checking bench for mantissa_divider24: scoreboard of expected results from an
// arithmetic model, latency/handshake checks, busy-time input rejection and mid-op reset.
module tb_mantissa_divider24;

  localparam int MW = 24;
  localparam int QW = MW + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a;
  logic [MW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quo;
  logic          sticky;
  logic          dz;

  typedef struct {
    logic [QW-1:0] quo;
    logic          sticky;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;

  mantissa_divider24 #(.MW(MW), .QW(QW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .sticky    (sticky),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference model: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [MW-1:0] av, input logic [MW-1:0] bv);
    exp_t e;
    logic [63:0] num;
    if (bv == '0) begin
      e.quo    = '1;
      e.sticky = 1'b1;
      e.dz     = 1'b1;
      e.lat    = 1;
    end else begin
      num      = 64'(av) << (QW - 1);
      e.quo    = QW'(num / 64'(bv));
      e.sticky = (num % 64'(bv)) != 0;
      e.dz     = 1'b0;
      e.lat    = QW;
    end
    return e;
  endfunction

  // Present operands for one accepting edge; leaves time at posedge+1.
  task automatic issue(input logic [MW-1:0] av, input logic [MW-1:0] bv);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    exp_q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [MW-1:0] av, input logic [MW-1:0] bv, input int hold);
    int            lat;
    exp_t          e;
    logic [QW-1:0] q0;
    logic          s0;
    issue(av, bv);
    check("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check("timeout_out_valid", 64'(out_valid), 64'd1);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    check("quo", 64'(quo), 64'(e.quo));
    check("sticky", 64'(sticky), 64'(e.sticky));
    check("dz", 64'(dz), 64'(e.dz));
    check("latency", 64'(lat), 64'(e.lat));
    q0 = quo;
    s0 = sticky;
    for (int i = 0; i < hold; i++) begin
      a        = 24'hC00000;
      b        = 24'h900000;
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
      check("hold_quo", 64'(quo), 64'(q0));
      check("hold_sticky", 64'(sticky), 64'(s0));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quo", 64'(quo), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, then one held in DONE with busy in_valid pulses.
    run_op(24'h800000, 24'h800000, 0);
    check("dir_1_0", 64'(quo), 64'h2000000);
    run_op(24'h800000, 24'hC00000, 0);
    check("dir_2_3", 64'(quo), 64'h1555555);
    run_op(24'hFFFFFF, 24'h800000, 0);
    check("dir_max", 64'(quo), 64'h3FFFFFC);
    run_op(24'h123456, 24'h000000, 0);
    check("dir_dz", 64'(quo), 64'h3FFFFFF);
    run_op(24'hFFFFFF, 24'hFFFFFF, 0);
    run_op(24'h800000, 24'hFFFFFF, 0);
    run_op(24'hABCDEF, 24'h987654, 5);
    run_op(24'hABCDEF, 24'h000000, 3);

    // Random normalized operands.
    for (int i = 0; i < 8; i++) begin
      run_op(24'h800000 | 24'($urandom_range(0, 24'h7FFFFF)),
             24'h800000 | 24'($urandom_range(0, 24'h7FFFFF)), 0);
    end

    // Reset during RUN: the op is dropped, no result may appear.
    issue(24'h900000, 24'hA00000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    void'(exp_q.pop_front());
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    check("abort_no_result", 64'(bad), 64'd0);
    run_op(24'h800000, 24'h800000, 0);
    check("post_abort", 64'(quo), 64'h2000000);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
